capi_seq_retire_mgr: RTL and testbench

- In-order retire stage that sits directly upstream of the sequential tag allocator.
- Snoops tags as they are issued, accepts out-of-order completions, and retires tags strictly in issue order.
- The retire handshake drives the allocator's free port (free_v/free_id), so tags return in the sequence the allocator's tag check requires.
- Flags protocol violations: duplicate issue, completion of a tag that is not outstanding, and double completion.

---
 rtl/capi_seq_pkg.sv | 10 +
 rtl/capi_seq_sts_array.sv | 26 ++
 rtl/capi_seq_retire_mgr.sv | 133 +++++++++++++
 tb/tb_capi_seq_retire_mgr.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/capi_seq_pkg.sv
// Shared definitions for the sequential-tag retire path: error codes reported on o_err_type.
// A code of 00 means no error and only appears while o_err_v is low.
package capi_seq_pkg;

   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_DUP_ALLOC = 2'b01;
   localparam logic [1:0] ERR_CMPL_NOUT = 2'b10;
   localparam logic [1:0] ERR_DUP_CMPL  = 2'b11;

endpackage

// File: rtl/capi_seq_sts_array.sv
// Per-tag completion status store: one synchronous write port, one asynchronous read port.
// Write lands at the edge; read is combinational from the array. Contents are not reset.
module capi_seq_sts_array #(
   parameter int id_width  = 4,
   parameter int num_res   = 2**id_width,
   parameter int sts_width = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [id_width-1:0]  waddr,
   input  logic [sts_width-1:0] wdata,
   input  logic [id_width-1:0]  raddr,
   output logic [sts_width-1:0] rdata
);

   logic [sts_width-1:0] mem [num_res];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/capi_seq_retire_mgr.sv
// In-order retire of sequentially issued tags; completions arrive out of order, retire needs done[rptr].
// o_ret_v is combinational from state (completion -> retire >= 1 cycle); o_ret_r low holds the retire stable.
module capi_seq_retire_mgr
   import capi_seq_pkg::*;
#(
   parameter int id_width  = 4,
   parameter int num_res   = 2**id_width,
   parameter int sts_width = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_alloc_v,
   input  logic [id_width-1:0]  i_alloc_id,
   input  logic                 i_cmpl_v,
   input  logic [id_width-1:0]  i_cmpl_id,
   input  logic [sts_width-1:0] i_cmpl_sts,
   output logic                 o_ret_v,
   output logic [id_width-1:0]  o_ret_id,
   output logic [sts_width-1:0] o_ret_sts,
   input  logic                 o_ret_r,
   output logic                 o_free_v,
   output logic [id_width-1:0]  o_free_id,
   output logic [id_width:0]    o_outst,
   output logic                 o_err_v,
   output logic [1:0]           o_err_type
);

   localparam logic [id_width-1:0] RPTR_ONE = 1;
   localparam logic [id_width:0]   CNT_ONE  = 1;

   logic [num_res-1:0]  outst_q, outst_nxt;
   logic [num_res-1:0]  done_q, done_nxt;
   logic [id_width-1:0] rptr_q;
   logic [id_width:0]   cnt_q, cnt_nxt;
   logic                err_v_q;
   logic [1:0]          err_type_q;

   logic ret_fire;
   logic alloc_err, alloc_ok;
   logic cmpl_nout, cmpl_dup, cmpl_ok;
   logic err_v_nxt;
   logic [1:0] err_type_nxt;

   assign ret_fire = done_q[rptr_q] & o_ret_r;

   // Re-issuing the tag that retires this very cycle is legal: it is leaving as it comes back.
   assign alloc_err = i_alloc_v & outst_q[i_alloc_id] & ~(ret_fire && (i_alloc_id == rptr_q));
   assign alloc_ok  = i_alloc_v & ~alloc_err;

   // Completion checks use pre-edge outst, so a same-cycle alloc of the id does not cover it.
   assign cmpl_nout = i_cmpl_v & ~outst_q[i_cmpl_id];
   assign cmpl_dup  = i_cmpl_v &  outst_q[i_cmpl_id] &  done_q[i_cmpl_id];
   assign cmpl_ok   = i_cmpl_v &  outst_q[i_cmpl_id] & ~done_q[i_cmpl_id];

   always_comb begin
      outst_nxt = outst_q;
      done_nxt  = done_q;
      if (ret_fire) begin
         outst_nxt[rptr_q] = 1'b0;
         done_nxt[rptr_q]  = 1'b0;
      end
      // Set after clear so a same-cycle re-issue of the retiring tag leaves it outstanding.
      if (i_alloc_v) begin
         outst_nxt[i_alloc_id] = 1'b1;
      end
      if (cmpl_ok) begin
         done_nxt[i_cmpl_id] = 1'b1;
      end
   end

   always_comb begin
      cnt_nxt = cnt_q;
      unique case ({alloc_ok, ret_fire})
         2'b10:   cnt_nxt = cnt_q + CNT_ONE;
         2'b01:   cnt_nxt = cnt_q - CNT_ONE;
         default: cnt_nxt = cnt_q;
      endcase
   end

   always_comb begin
      err_v_nxt    = alloc_err | cmpl_nout | cmpl_dup;
      err_type_nxt = ERR_NONE;
      if (cmpl_nout) begin
         err_type_nxt = ERR_CMPL_NOUT;
      end else if (cmpl_dup) begin
         err_type_nxt = ERR_DUP_CMPL;
      end else if (alloc_err) begin
         err_type_nxt = ERR_DUP_ALLOC;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         outst_q    <= '0;
         done_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         err_v_q    <= 1'b0;
         err_type_q <= ERR_NONE;
      end else begin
         outst_q    <= outst_nxt;
         done_q     <= done_nxt;
         cnt_q      <= cnt_nxt;
         err_v_q    <= err_v_nxt;
         err_type_q <= err_type_nxt;
         if (ret_fire) begin
            rptr_q <= rptr_q + RPTR_ONE;
         end
      end
   end

   capi_seq_sts_array #(
      .id_width  (id_width),
      .num_res   (num_res),
      .sts_width (sts_width)
   ) u_sts (
      .clk   (clk),
      .we    (cmpl_ok),
      .waddr (i_cmpl_id),
      .wdata (i_cmpl_sts),
      .raddr (rptr_q),
      .rdata (o_ret_sts)
   );

   assign o_ret_v    = done_q[rptr_q];
   assign o_ret_id   = rptr_q;
   assign o_free_v   = ret_fire;
   assign o_free_id  = rptr_q;
   assign o_outst    = cnt_q;
   assign o_err_v    = err_v_q;
   assign o_err_type = err_type_q;

endmodule

// File: tb/tb_capi_seq_retire_mgr.sv
// Directed bench for capi_seq_retire_mgr: ordering, backpressure, wrap, fill, errors, mid-run reset.
module tb_capi_seq_retire_mgr;

   localparam int IDW  = 4;
   localparam int NRES = 16;
   localparam int STSW = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            i_alloc_v = 1'b0;
   logic [IDW-1:0]  i_alloc_id = '0;
   logic            i_cmpl_v = 1'b0;
   logic [IDW-1:0]  i_cmpl_id = '0;
   logic [STSW-1:0] i_cmpl_sts = '0;
   logic            o_ret_v;
   logic [IDW-1:0]  o_ret_id;
   logic [STSW-1:0] o_ret_sts;
   logic            o_ret_r = 1'b0;
   logic            o_free_v;
   logic [IDW-1:0]  o_free_id;
   logic [IDW:0]    o_outst;
   logic            o_err_v;
   logic [1:0]      o_err_type;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   capi_seq_retire_mgr #(.id_width(IDW), .num_res(NRES), .sts_width(STSW)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_alloc_v  (i_alloc_v),
      .i_alloc_id (i_alloc_id),
      .i_cmpl_v   (i_cmpl_v),
      .i_cmpl_id  (i_cmpl_id),
      .i_cmpl_sts (i_cmpl_sts),
      .o_ret_v    (o_ret_v),
      .o_ret_id   (o_ret_id),
      .o_ret_sts  (o_ret_sts),
      .o_ret_r    (o_ret_r),
      .o_free_v   (o_free_v),
      .o_free_id  (o_free_id),
      .o_outst    (o_outst),
      .o_err_v    (o_err_v),
      .o_err_type (o_err_type)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_alloc_v  = 1'b0;
      i_alloc_id = '0;
      i_cmpl_v   = 1'b0;
      i_cmpl_id  = '0;
      i_cmpl_sts = '0;
   endtask

   task automatic do_reset();
      idle();
      o_ret_r = 1'b0;
      reset   = 1'b1;
      cyc();
      cyc();
      reset   = 1'b0;
   endtask

   task automatic alloc(input int id);
      idle();
      i_alloc_v  = 1'b1;
      i_alloc_id = IDW'(id);
      cyc();
      idle();
   endtask

   task automatic cmpl(input int id, input int sts);
      idle();
      i_cmpl_v   = 1'b1;
      i_cmpl_id  = IDW'(id);
      i_cmpl_sts = STSW'(sts);
      cyc();
      idle();
   endtask

   initial begin
      int exp_sts [3];
      int free_cnt;
      exp_sts = '{'h00, 'h11, 'h22};

      // reset state
      do_reset();
      chk("rst_ret_v", 32'(o_ret_v), 0);
      chk("rst_free_v", 32'(o_free_v), 0);
      chk("rst_outst", 32'(o_outst), 0);
      chk("rst_err_v", 32'(o_err_v), 0);
      chk("rst_err_type", 32'(o_err_type), 0);

      // out-of-order completion, in-order retire
      o_ret_r = 1'b1;
      alloc(0); alloc(1); alloc(2);
      chk("ooo_outst3", 32'(o_outst), 3);
      cmpl(2, 'h22);
      chk("ooo_noret_a", 32'(o_ret_v), 0);
      cmpl(1, 'h11);
      chk("ooo_noret_b", 32'(o_ret_v), 0);
      cmpl(0, 'h00);
      for (int k = 0; k < 3; k++) begin
         chk("ooo_ret_v", 32'(o_ret_v), 1);
         chk("ooo_ret_id", 32'(o_ret_id), 32'(k));
         chk("ooo_ret_sts", 32'(o_ret_sts), 32'(exp_sts[k]));
         chk("ooo_free_v", 32'(o_free_v), 1);
         chk("ooo_outst", 32'(o_outst), 32'(3 - k));
         cyc();
      end
      chk("ooo_end_ret_v", 32'(o_ret_v), 0);
      chk("ooo_end_outst", 32'(o_outst), 0);

      // backpressure holds the retire stable
      do_reset();
      alloc(0);
      cmpl(0, 'h5A);
      repeat (5) begin
         chk("bp_ret_v", 32'(o_ret_v), 1);
         chk("bp_ret_id", 32'(o_ret_id), 0);
         chk("bp_ret_sts", 32'(o_ret_sts), 'h5A);
         chk("bp_free_v", 32'(o_free_v), 0);
         cyc();
      end
      o_ret_r  = 1'b1;
      free_cnt = 0;
      repeat (4) begin
         #1;
         if (o_free_v) begin
            free_cnt++;
            chk("bp_free_id", 32'(o_free_id), 0);
         end
         cyc();
      end
      chk("bp_free_cnt", 32'(free_cnt), 1);
      chk("bp_outst", 32'(o_outst), 0);

      // retire pointer wrap
      do_reset();
      o_ret_r = 1'b1;
      for (int i = 0; i < 20; i++) begin
         alloc(i % 16);
         cmpl(i % 16, i);
         chk("wrap_free_v", 32'(o_free_v), 1);
         chk("wrap_free_id", 32'(o_free_id), 32'(i % 16));
         cyc();
      end
      chk("wrap_rptr", 32'(o_ret_id), 4);
      chk("wrap_outst", 32'(o_outst), 0);
      chk("wrap_ret_v", 32'(o_ret_v), 0);
      chk("wrap_err_v", 32'(o_err_v), 0);

      // fill all tags, complete in reverse, drain back-to-back
      do_reset();
      o_ret_r = 1'b1;
      for (int i = 0; i < 16; i++) alloc(i);
      chk("fill_outst16", 32'(o_outst), 16);
      for (int i = 15; i >= 0; i--) begin
         cmpl(i, 'hA0 | i);
         if (i != 0) chk("fill_noret", 32'(o_ret_v), 0);
      end
      for (int k = 0; k < 16; k++) begin
         chk("fill_free_v", 32'(o_free_v), 1);
         chk("fill_free_id", 32'(o_free_id), 32'(k));
         chk("fill_ret_sts", 32'(o_ret_sts), 32'('hA0 | k));
         chk("fill_outst", 32'(o_outst), 32'(16 - k));
         cyc();
      end
      chk("fill_end_outst", 32'(o_outst), 0);
      chk("fill_end_ret_v", 32'(o_ret_v), 0);
      chk("fill_end_rptr", 32'(o_ret_id), 0);

      // protocol errors
      do_reset();
      o_ret_r = 1'b1;
      cmpl(5, 'h55);
      chk("err_nout_v", 32'(o_err_v), 1);
      chk("err_nout_type", 32'(o_err_type), 2);
      chk("err_nout_noret", 32'(o_ret_v), 0);
      cyc();
      chk("err_pulse_end", 32'(o_err_v), 0);
      alloc(3);
      cmpl(3, 'h33);
      chk("err_first_cmpl", 32'(o_err_v), 0);
      cmpl(3, 'h34);
      chk("err_dup_cmpl_v", 32'(o_err_v), 1);
      chk("err_dup_cmpl_type", 32'(o_err_type), 3);
      alloc(3);
      chk("err_dup_alloc_v", 32'(o_err_v), 1);
      chk("err_dup_alloc_type", 32'(o_err_type), 1);
      idle();
      i_alloc_v = 1'b1; i_alloc_id = 4'd3;
      i_cmpl_v  = 1'b1; i_cmpl_id  = 4'd5;
      cyc();
      idle();
      chk("err_both_type", 32'(o_err_type), 2);
      // completion in the same cycle as the tag's own issue is not outstanding yet
      idle();
      i_alloc_v = 1'b1; i_alloc_id = 4'd7;
      i_cmpl_v  = 1'b1; i_cmpl_id  = 4'd7;
      cyc();
      idle();
      chk("err_same_cyc_v", 32'(o_err_v), 1);
      chk("err_same_cyc_type", 32'(o_err_type), 2);
      cmpl(7, 'h77);
      chk("err_after_same_cyc", 32'(o_err_v), 0);
      // a bad completion does not hold up a retire in the same cycle
      alloc(0);
      cmpl(0, 'h01);
      i_cmpl_v = 1'b1; i_cmpl_id = 4'd9;
      #1;
      chk("err_noStall_free_v", 32'(o_free_v), 1);
      chk("err_noStall_free_id", 32'(o_free_id), 0);
      cyc();
      idle();
      chk("err_noStall_err", 32'(o_err_type), 2);
      chk("err_noStall_rptr", 32'(o_ret_id), 1);

      // reset in the middle of traffic
      do_reset();
      for (int i = 0; i < 6; i++) alloc(i);
      cmpl(0, 'h10);
      cmpl(1, 'h11);
      chk("mid_outst6", 32'(o_outst), 6);
      chk("mid_ret_v", 32'(o_ret_v), 1);
      reset = 1'b1;
      i_cmpl_v = 1'b1; i_cmpl_id = 4'd9;
      cyc();
      idle();
      reset = 1'b0;
      chk("mid_rst_ret_v", 32'(o_ret_v), 0);
      chk("mid_rst_outst", 32'(o_outst), 0);
      chk("mid_rst_err_v", 32'(o_err_v), 0);
      alloc(0);
      cmpl(0, 'h77);
      o_ret_r = 1'b1;
      i_alloc_v = 1'b1; i_alloc_id = 4'd0;
      #1;
      chk("mid_ret_id", 32'(o_ret_id), 0);
      chk("mid_ret_sts", 32'(o_ret_sts), 'h77);
      chk("mid_free_v", 32'(o_free_v), 1);
      cyc();
      idle();
      chk("reissue_err_v", 32'(o_err_v), 0);
      chk("reissue_outst", 32'(o_outst), 1);
      chk("reissue_rptr", 32'(o_ret_id), 1);
      cmpl(0, 'h78);
      chk("reissue_cmpl_ok", 32'(o_err_v), 0);
      chk("reissue_noret", 32'(o_ret_v), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
